// File: rtl/dds_cmd_pkg.sv
// Shared opcodes, FSM state encoding and readback selects for the DDS command controller.
package dds_cmd_pkg;

    localparam logic [7:0] OP_FTW1      = 8'h70;
    localparam logic [7:0] OP_FTW2      = 8'h71;
    localparam logic [7:0] OP_PH1       = 8'h60;
    localparam logic [7:0] OP_PH2       = 8'h61;
    localparam logic [7:0] OP_COMMIT    = 8'h80;
    localparam logic [7:0] OP_RUN       = 8'hC1;
    localparam logic [7:0] OP_STOP      = 8'hC0;
    localparam logic [7:0] OP_RD_FTW1   = 8'hA0;
    localparam logic [7:0] OP_RD_FTW2   = 8'hA1;
    localparam logic [7:0] OP_RD_PH1    = 8'hA2;
    localparam logic [7:0] OP_RD_PH2    = 8'hA3;
    localparam logic [7:0] OP_RD_STATUS = 8'hA4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_WAIT_SYNC = 3'd2;
    localparam logic [2:0] ST_APPLY     = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    // Readback select is the low three opcode bits of the 0xA0-0xA4 group.
    localparam logic [2:0] RD_SEL_FTW1   = 3'd0;
    localparam logic [2:0] RD_SEL_FTW2   = 3'd1;
    localparam logic [2:0] RD_SEL_PH1    = 3'd2;
    localparam logic [2:0] RD_SEL_PH2    = 3'd3;
    localparam logic [2:0] RD_SEL_STATUS = 3'd4;

    function automatic logic is_ftw_op(input logic [7:0] op);
        return op[7:1] == OP_FTW1[7:1];
    endfunction

    function automatic logic is_ph_op(input logic [7:0] op);
        return op[7:1] == OP_PH1[7:1];
    endfunction

    function automatic logic is_rd_op(input logic [7:0] op);
        return (op >= OP_RD_FTW1) && (op <= OP_RD_STATUS);
    endfunction

endpackage

// File: rtl/dds_shadow_reg.sv
// Shadow/active register pair: writes land in the shadow copy, commit moves it to the output.
module dds_shadow_reg
    import dds_cmd_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         commit,
    output logic [W-1:0] active_q
);

    logic [W-1:0] shadow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (wr_en)
                shadow_q <= wr_data;
            if (commit)
                active_q <= shadow_q;
        end
    end

endmodule

// File: rtl/dds_cmd_ctrl.sv
// Command controller: decodes SPI frames into shadow register writes, sync-aligned commits,
// run/stop control and readback responses for the two DDS channels.
module dds_cmd_ctrl
    import dds_cmd_pkg::*;
#(
    parameter int FTW_W = 24,
    parameter int PH_W  = 12,
    parameter int ERR_W = 8
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    input  logic             frm_valid_i,
    output logic             frm_ready_o,
    input  logic [31:0]      frm_data_i,
    input  logic             dds_sync_i,
    output logic [FTW_W-1:0] ch1_ftw_o,
    output logic [FTW_W-1:0] ch2_ftw_o,
    output logic [PH_W-1:0]  ch1_ph_o,
    output logic [PH_W-1:0]  ch2_ph_o,
    output logic             run_o,
    output logic             acc_clr_o,
    output logic [31:0]      rsp_data_o,
    output logic             rsp_valid_o,
    input  logic             rsp_ack_i,
    output logic [ERR_W-1:0] err_cnt_o
);

    logic [2:0]  state;
    logic [31:0] frame;
    logic        start_flag;
    logic        pending;
    logic [7:0]  opcode;
    logic [23:0] payload;
    logic [1:0]  ftw_wr;
    logic [1:0]  ph_wr;
    logic        commit;
    logic [23:0] status_field;
    logic [31:0] rd_word;

    assign opcode      = frame[31:24];
    assign payload     = frame[23:0];
    assign frm_ready_o = (state == ST_IDLE);
    assign commit      = (state == ST_APPLY);

    always_comb begin
        ftw_wr = '0;
        ph_wr  = '0;
        if (state == ST_DECODE) begin
            if (is_ftw_op(opcode))
                ftw_wr[opcode[0]] = 1'b1;
            if (is_ph_op(opcode))
                ph_wr[opcode[0]] = 1'b1;
        end
    end

    always_comb begin
        status_field               = '0;
        status_field[23]           = run_o;
        status_field[22]           = pending;
        status_field[21 -: ERR_W]  = err_cnt_o;
        case (opcode[2:0])
            RD_SEL_FTW1:   rd_word = {opcode, 24'(ch1_ftw_o)};
            RD_SEL_FTW2:   rd_word = {opcode, 24'(ch2_ftw_o)};
            RD_SEL_PH1:    rd_word = {opcode, 24'(ch1_ph_o)};
            RD_SEL_PH2:    rd_word = {opcode, 24'(ch2_ph_o)};
            RD_SEL_STATUS: rd_word = {opcode, status_field};
            default:       rd_word = {opcode, 24'h0};
        endcase
    end

    // run_o follows the clear pulse by one cycle so the accumulators restart from zero.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state       <= ST_IDLE;
            frame       <= '0;
            start_flag  <= 1'b0;
            pending     <= 1'b0;
            run_o       <= 1'b0;
            acc_clr_o   <= 1'b0;
            rsp_data_o  <= '0;
            rsp_valid_o <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            acc_clr_o <= 1'b0;
            if (acc_clr_o)
                run_o <= 1'b1;
            if (rsp_ack_i)
                rsp_valid_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (frm_valid_i) begin
                        frame <= frm_data_i;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state <= ST_IDLE;
                    if (is_ftw_op(opcode) || is_ph_op(opcode)) begin
                        state <= ST_IDLE;
                    end else if (opcode == OP_COMMIT) begin
                        if (run_o) begin
                            pending <= 1'b1;
                            state   <= ST_WAIT_SYNC;
                        end else begin
                            state <= ST_APPLY;
                        end
                    end else if (opcode == OP_RUN) begin
                        start_flag <= 1'b1;
                        state      <= ST_APPLY;
                    end else if (opcode == OP_STOP) begin
                        run_o <= 1'b0;
                    end else if (is_rd_op(opcode)) begin
                        state <= ST_RESP;
                    end else if (err_cnt_o != '1) begin
                        err_cnt_o <= err_cnt_o + ERR_W'(1);
                    end
                end
                ST_WAIT_SYNC: begin
                    if (dds_sync_i)
                        state <= ST_APPLY;
                end
                ST_APPLY: begin
                    pending    <= 1'b0;
                    start_flag <= 1'b0;
                    if (start_flag)
                        acc_clr_o <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_RESP: begin
                    rsp_data_o  <= rd_word;
                    rsp_valid_o <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    dds_shadow_reg #(.W(FTW_W)) u_ftw1 (
        .clk      (sys_clk_i),
        .rst_n    (sys_rst_i),
        .wr_en    (ftw_wr[0]),
        .wr_data  (payload[FTW_W-1:0]),
        .commit   (commit),
        .active_q (ch1_ftw_o)
    );

    dds_shadow_reg #(.W(FTW_W)) u_ftw2 (
        .clk      (sys_clk_i),
        .rst_n    (sys_rst_i),
        .wr_en    (ftw_wr[1]),
        .wr_data  (payload[FTW_W-1:0]),
        .commit   (commit),
        .active_q (ch2_ftw_o)
    );

    dds_shadow_reg #(.W(PH_W)) u_ph1 (
        .clk      (sys_clk_i),
        .rst_n    (sys_rst_i),
        .wr_en    (ph_wr[0]),
        .wr_data  (payload[PH_W-1:0]),
        .commit   (commit),
        .active_q (ch1_ph_o)
    );

    dds_shadow_reg #(.W(PH_W)) u_ph2 (
        .clk      (sys_clk_i),
        .rst_n    (sys_rst_i),
        .wr_en    (ph_wr[1]),
        .wr_data  (payload[PH_W-1:0]),
        .commit   (commit),
        .active_q (ch2_ph_o)
    );

endmodule
